// File: rtl/twofish_stream_if_if.sv
// rtl/twofish_stream_if_if.sv - word stream handshake bundle for the Twofish front/back-end
interface twofish_stream_if_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/twofish_stream_if.sv
// rtl/twofish_stream_if.sv - word-serial block assembly, settle wait and ciphertext serialiser around a combinational Twofish core
module twofish_stream_if #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_we,
  input  logic [127:0]         key_i,
  output logic                 key_loaded,
  twofish_stream_if_if.slave   strm,
  output logic                 busy,
  output logic [CNT_W-1:0]     blk_cnt,
  output logic [127:0]         key_o,
  output logic [127:0]         pt_o,
  input  logic [127:0]         ct_i
);

  typedef enum logic [1:0] {LOAD, WAIT, OUT} state_t;

  state_t       state_q, state_d;
  logic [1:0]   wcnt;
  logic [1:0]   oidx;
  logic [7:0]   settle;
  logic [127:0] ct_q;
  logic         out_valid_q;
  logic [31:0]  out_data_q;
  logic         key_take, in_hs, out_hs;
  logic         last_in, capture, last_out;

  function automatic logic [31:0] word_sel(input logic [127:0] blk, input logic [1:0] idx);
    logic [31:0] w;
    case (idx)
      2'd0: w = blk[127:96];
      2'd1: w = blk[95:64];
      2'd2: w = blk[63:32];
      2'd3: w = blk[31:0];
    endcase
    return w;
  endfunction

  // A key load takes priority over the first word of a block in the same cycle.
  assign key_take      = key_we & (state_q == LOAD) & (wcnt == 2'd0);
  assign strm.in_ready = key_loaded & (state_q == LOAD) & ~(key_we & (wcnt == 2'd0));
  assign busy          = (state_q != LOAD) | (wcnt != 2'd0);
  assign in_hs         = strm.in_valid & strm.in_ready;
  assign out_hs        = out_valid_q & strm.out_ready;
  assign strm.out_valid = out_valid_q;
  assign strm.out_data  = out_data_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    last_in  = 1'b0;
    capture  = 1'b0;
    last_out = 1'b0;
    case (state_q)
      LOAD: if (in_hs && wcnt == 2'd3) begin
        last_in = 1'b1;
        state_d = WAIT;
      end
      WAIT: if (settle == 8'd1) begin
        capture = 1'b1;
        state_d = OUT;
      end
      OUT: if (out_hs && oidx == 2'd3) begin
        last_out = 1'b1;
        state_d  = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt        <= 2'd0;
      oidx        <= 2'd0;
      settle      <= 8'd0;
      ct_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      blk_cnt     <= '0;
      key_o       <= '0;
      pt_o        <= '0;
      key_loaded  <= 1'b0;
    end else begin
      if (key_take) begin
        key_o      <= key_i;
        key_loaded <= 1'b1;
      end
      if (in_hs) begin
        wcnt <= wcnt + 2'd1;
        case (wcnt)
          2'd0: pt_o[127:96] <= strm.in_data;
          2'd1: pt_o[95:64]  <= strm.in_data;
          2'd2: pt_o[63:32]  <= strm.in_data;
          2'd3: pt_o[31:0]   <= strm.in_data;
        endcase
      end
      // The core output is only trusted once the settle count has run out.
      if (last_in)
        settle <= 8'(SETTLE_CYCLES);
      else if (state_q == WAIT)
        settle <= settle - 8'd1;
      if (capture) begin
        ct_q        <= ct_i;
        oidx        <= 2'd0;
        out_valid_q <= 1'b1;
        out_data_q  <= ct_i[127:96];
      end else if (out_hs) begin
        oidx       <= oidx + 2'd1;
        out_data_q <= word_sel(ct_q, oidx + 2'd1);
        if (last_out) begin
          out_valid_q <= 1'b0;
          blk_cnt     <= blk_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

endmodule

// File: doc/twofish_stream_if.md
Name: twofish_stream_if

Overview:
- Sequential front-end and back-end for the combinational Twofish-128 encryption core.
- Holds a registered 128-bit key and assembles four 32-bit input words into a 128-bit plaintext block, which it drives to the core.
- Waits a fixed number of settle cycles, because the core is a deep combinational multicycle path, then captures the 128-bit ciphertext.
- Serialises the ciphertext as four 32-bit words over a valid/ready handshake.

Parameters:
- SETTLE_CYCLES, default 4: cycles between the plaintext register being stable and ciphertext capture. Legal range 1..255; the multicycle constraint on the core is set to match.
- CNT_W, default 16: width of the completed-block counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- key_we  in  1  load key_i into key register (one-cycle strobe)
- key_i  in  128  cipher key
- key_loaded  out  1  a key has been loaded since reset
- in_valid  in  1  in_data valid
- in_data  in  32  plaintext word; first word → pt_o[127:96]
- in_ready  out  1  block accepts an input word this cycle
- out_valid  out  1  out_data valid
- out_data  out  32  ciphertext word; first word = ct[127:96]
- out_ready  in  1  sink accepts out_data
- busy  out  1  state is not LOAD, or word count ≠ 0
- blk_cnt  out  CNT_W  completed blocks, wraps modulo 2^CNT_W
- key_o  out  128  to core key input (the key register)
- pt_o  out  128  to core plain_text input (the plaintext register)
- ct_i  in  128  from core encrypt output

Behaviour:
- Reset values:
  - State LOAD; word count 0.
  - key_o, pt_o, captured ciphertext, blk_cnt all 0.
  - key_loaded, in_ready, out_valid, busy all 0; out_data 0.
- Reset mid-operation aborts the block in progress, discards partial words, and clears key_loaded.
- Key load:
  - key_we is honoured only when state = LOAD and word count = 0. Otherwise it is ignored and the key is unchanged.
  - When honoured: key_o ← key_i, key_loaded ← 1.
  - Reloading a key when idle is allowed.
- in_ready = key_loaded & (state = LOAD) & !(key_we & word count = 0). Key load wins over the first input word in the same cycle.
- State LOAD:
  - Each in_valid & in_ready cycle writes in_data into pt_o slot [127-32n : 96-32n], n = word count, then word count increments.
  - On the 4th accepted word: word count ← 0, settle counter ← SETTLE_CYCLES, go to WAIT.
  - pt_o and key_o stay constant from this point until return to LOAD.
- State WAIT:
  - Settle counter decrements each cycle.
  - When it is 1: capture ct_i into the ciphertext register, out word index ← 0, out_valid ← 1, go to OUT.
  - First capture occurs SETTLE_CYCLES cycles after the cycle of the 4th input handshake.
- State OUT:
  - out_data = ciphertext word selected by index (index 0 = [127:96]).
  - out_data is stable while out_valid & !out_ready.
  - On out_valid & out_ready: index increments.
  - After the 4th handshake: out_valid ← 0, blk_cnt ← blk_cnt + 1 (wrapping), go to LOAD.
  - in_ready rises the cycle after the 4th output handshake. No input overlap with output: one block in flight.
- Minimum block period: 4 (input) + SETTLE_CYCLES + 4 (output) cycles with no backpressure.
- in_valid while in_ready = 0 is ignored; no data is consumed.
- out_valid never deasserts before its handshake completes.
- All outputs are registered except in_ready and busy, which are combinational from state, word count and key_we only.
- ct_i is sampled only on the capture cycle; changes at other times are ignored.

Test Plan:
- Stub core ct_i = ~pt_o ^ key_o; rst; key_we with key_i = 0; stream words 00112233, 44556677, 8899AABB, CCDDEEFF, out_ready = 1 → out_data FFEEDDCC, BBAA9988, 77665544, 33221100 appearing SETTLE_CYCLES (4) cycles after the 4th input handshake; blk_cnt = 1.
- No key loaded after reset, in_valid = 1 → in_ready stays 0; no state change; key_loaded = 0.
- key_we and in_valid together at word count 0 → key taken, word not consumed (in_ready = 0), word accepted next cycle.
- Hold out_ready = 0 for 10 cycles in OUT → out_valid = 1 and out_data stable at word 0; in_ready = 0; key_we ignored (key_o unchanged).
- rst asserted after 2 input words → next cycle state LOAD, word count 0, pt_o = 0, key_loaded = 0, out_valid = 0.
- CNT_W = 2; run 5 back-to-back blocks with random stall patterns → blk_cnt sequence 1, 2, 3, 0, 1; every output word matches the stub model.
